// File: rtl/jump_base_resolver_pkg.sv
// Shared definitions for the register-based jump base resolver.
//   - Instruction field positions for the register-jump opcode.
//   - FSM state encoding shared by the top and anything that observes it.
//   - is_reg_jump(): decodes one instruction word as a register-based jump.
package jump_base_resolver_pkg;

  localparam int INSTR_W = 16;

  localparam int          OP_MSB       = 15;
  localparam int          OP_LSB       = 12;
  localparam logic [3:0]  OP_JUMP      = 4'hF;
  localparam int          JMP_REG_BIT  = 0;
  localparam int          JMP_BASE_MSB = 11;
  localparam int          JMP_BASE_LSB = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } jr_state_e;

  function automatic logic is_reg_jump(input logic [INSTR_W-1:0] instr);
    return (instr[OP_MSB:OP_LSB] == OP_JUMP) && instr[JMP_REG_BIT];
  endfunction

endpackage

// File: rtl/jr_slot_scan.sv
// Combinational priority finder over the 4-wide decode bundle.
// Finds the oldest (lowest slot) register-based jump, extracts its base
// register index, and reports whether an older slot in the same bundle
// writes that base register (the scoreboard does not see those yet).
// Ports:
//   instr0..instr3  in   decode bundle, slot0 oldest
//   wr_en           in   per-slot "writes a register"
//   wr_reg          in   per-slot dest index, slot i at [i*AREG_W +: AREG_W]
//   hit             out  a register jump exists in the bundle
//   base            out  base register index of the winning jump
//   pend            out  an older slot in this bundle writes base
module jr_slot_scan
  import jump_base_resolver_pkg::*;
#(
  parameter int AREG_W = 4
) (
  input  logic [INSTR_W-1:0]  instr0,
  input  logic [INSTR_W-1:0]  instr1,
  input  logic [INSTR_W-1:0]  instr2,
  input  logic [INSTR_W-1:0]  instr3,
  input  logic [3:0]          wr_en,
  input  logic [4*AREG_W-1:0] wr_reg,
  output logic                hit,
  output logic [AREG_W-1:0]   base,
  output logic                pend
);

  logic [INSTR_W-1:0] instr_a [4];
  logic [1:0]         slot;

  always_comb begin
    instr_a[0] = instr0;
    instr_a[1] = instr1;
    instr_a[2] = instr2;
    instr_a[3] = instr3;
  end

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // otherwise synthesis infers a latch to hold the old value.
    hit  = 1'b0;
    slot = 2'd0;
    base = '0;
    pend = 1'b0;

    // Walk from the youngest slot down so the oldest match overwrites last.
    for (int i = 3; i >= 0; i--) begin
      if (is_reg_jump(instr_a[i])) begin
        hit  = 1'b1;
        slot = 2'(i);
        base = AREG_W'(instr_a[i][JMP_BASE_MSB:JMP_BASE_LSB]);
      end
    end

    // Only writers older than the jump matter; younger ones execute after it.
    for (int i = 0; i < 3; i++) begin
      if (hit && (i < int'(slot)) && wr_en[i] &&
          (wr_reg[i*AREG_W +: AREG_W] == base)) begin
        pend = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jump_base_resolver.sv
// Responder side of the register-based jump handshake, sitting in decode next
// to the register file and scoreboard. Captures the oldest register jump in
// the decode bundle, waits until its base register is architecturally valid
// (via scoreboard, writeback bypass, or r0), then returns the base value with
// a one-cycle ready pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   has_mispredict           flush; aborts any in-flight resolution
//   dec_instr0..3            decode bundle, slot0 oldest
//   dec_wr_en, dec_wr_reg    per-slot destination writes in the bundle
//   reg_busy                 scoreboard pending-write bits
//   rf_rd_addr, rf_rd_data   combinational register file read port
//   wb_en, wb_reg, wb_data   writeback ports snooped for bypass
//   jump_base_from_rf_0      resolved base value (registered)
//   jump_base_rdy_from_rf_0  one-cycle ready pulse (registered)
//   jr_busy                  resolver is not idle
//   jr_stall_cycles          saturating count of cycles spent waiting
module jump_base_resolver
  import jump_base_resolver_pkg::*;
#(
  parameter int NUM_WB = 2,
  parameter int AREG_W = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     has_mispredict,
  input  logic [INSTR_W-1:0]       dec_instr0,
  input  logic [INSTR_W-1:0]       dec_instr1,
  input  logic [INSTR_W-1:0]       dec_instr2,
  input  logic [INSTR_W-1:0]       dec_instr3,
  input  logic [3:0]               dec_wr_en,
  input  logic [4*AREG_W-1:0]      dec_wr_reg,
  input  logic [(2**AREG_W)-1:0]   reg_busy,
  output logic [AREG_W-1:0]        rf_rd_addr,
  input  logic [DATA_W-1:0]        rf_rd_data,
  input  logic [NUM_WB-1:0]        wb_en,
  input  logic [NUM_WB*AREG_W-1:0] wb_reg,
  input  logic [NUM_WB*DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0]        jump_base_from_rf_0,
  output logic                     jump_base_rdy_from_rf_0,
  output logic                     jr_busy,
  output logic [CNT_W-1:0]         jr_stall_cycles
);

  jr_state_e state_q, state_d;

  logic [AREG_W-1:0] base_q;
  logic              pend_q;
  logic              byp_vld_q;
  logic [DATA_W-1:0] byp_data_q;
  logic [DATA_W-1:0] base_out_q;
  logic              rdy_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              scan_hit;
  logic [AREG_W-1:0] scan_base;
  logic              scan_pend;

  logic [AREG_W-1:0] wb_tgt;
  logic              wb_hit;
  logic [DATA_W-1:0] wb_hit_data;

  logic              ready;
  logic [DATA_W-1:0] resolved;

  jr_slot_scan #(.AREG_W(AREG_W)) u_scan (
    .instr0 (dec_instr0),
    .instr1 (dec_instr1),
    .instr2 (dec_instr2),
    .instr3 (dec_instr3),
    .wr_en  (dec_wr_en),
    .wr_reg (dec_wr_reg),
    .hit    (scan_hit),
    .base   (scan_base),
    .pend   (scan_pend)
  );

  // Writeback snoop: in IDLE compare against the base being captured, in
  // WAIT against the held base. Lowest port index wins.
  always_comb begin
    wb_tgt      = (state_q == IDLE) ? scan_base : base_q;
    wb_hit      = 1'b0;
    wb_hit_data = '0;
    for (int p = NUM_WB - 1; p >= 0; p--) begin
      if (wb_en[p] && (wb_reg[p*AREG_W +: AREG_W] == wb_tgt)) begin
        wb_hit      = 1'b1;
        wb_hit_data = wb_data[p*DATA_W +: DATA_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (has_mispredict) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (scan_hit) state_d = WAIT;
        WAIT:    if (ready)    state_d = RESP;
        RESP:                  state_d = IDLE;
        default:               state_d = IDLE;
      endcase
    end
  end

  // Output / datapath-select logic.
  always_comb begin
    jr_busy    = (state_q != IDLE);
    rf_rd_addr = base_q;

    // r0 is hardwired to zero, so it never waits on the scoreboard.
    ready = (state_q == WAIT) &&
            ((base_q == '0) || byp_vld_q || wb_hit ||
             (!reg_busy[base_q] && !pend_q));

    if (base_q == '0)   resolved = '0;
    else if (wb_hit)    resolved = wb_hit_data;
    else if (byp_vld_q) resolved = byp_data_q;
    else                resolved = rf_rd_data;
  end

  // Captured base, bypass, response and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q     <= '0;
      pend_q     <= 1'b0;
      byp_vld_q  <= 1'b0;
      byp_data_q <= '0;
      base_out_q <= '0;
      rdy_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rdy_q <= 1'b0;
      if (has_mispredict) begin
        // base_out and the counter are deliberately held across a flush.
        pend_q    <= 1'b0;
        byp_vld_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (scan_hit) begin
              base_q <= scan_base;
              pend_q <= scan_pend;
              // A same-cycle writeback is only the final value if no older
              // slot in this bundle is about to overwrite the base again.
              if (wb_hit && !scan_pend) begin
                byp_vld_q  <= 1'b1;
                byp_data_q <= wb_hit_data;
              end else begin
                byp_vld_q  <= 1'b0;
              end
            end
          end
          WAIT: begin
            if (wb_hit) pend_q <= 1'b0;
            if (ready) begin
              base_out_q <= resolved;
              rdy_q      <= 1'b1;
            end else if (cnt_q != '1) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          RESP: begin
            byp_vld_q <= 1'b0;
            pend_q    <= 1'b0;
          end
          default: begin
            byp_vld_q <= 1'b0;
            pend_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign jump_base_from_rf_0     = base_out_q;
  assign jump_base_rdy_from_rf_0 = rdy_q;
  assign jr_stall_cycles         = cnt_q;

endmodule

// File: tb/tb_jump_base_resolver.sv
// Directed testbench for jump_base_resolver. Expected values are hand-derived
// constants; the register file is a small bench-side array read
// combinationally through rf_rd_addr.
module tb_jump_base_resolver;

  localparam int NUM_WB = 2;
  localparam int AREG_W = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  logic                     clk;
  logic                     rst;
  logic                     has_mispredict;
  logic [15:0]              dec_instr0, dec_instr1, dec_instr2, dec_instr3;
  logic [3:0]               dec_wr_en;
  logic [4*AREG_W-1:0]      dec_wr_reg;
  logic [(2**AREG_W)-1:0]   reg_busy;
  logic [AREG_W-1:0]        rf_rd_addr;
  logic [DATA_W-1:0]        rf_rd_data;
  logic [NUM_WB-1:0]        wb_en;
  logic [NUM_WB*AREG_W-1:0] wb_reg;
  logic [NUM_WB*DATA_W-1:0] wb_data;
  logic [DATA_W-1:0]        jump_base_from_rf_0;
  logic                     jump_base_rdy_from_rf_0;
  logic                     jr_busy;
  logic [CNT_W-1:0]         jr_stall_cycles;

  logic [DATA_W-1:0] rf_mem [16];

  int n_checks = 0;
  int n_errors = 0;

  jump_base_resolver #(
    .NUM_WB(NUM_WB), .AREG_W(AREG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .has_mispredict          (has_mispredict),
    .dec_instr0              (dec_instr0),
    .dec_instr1              (dec_instr1),
    .dec_instr2              (dec_instr2),
    .dec_instr3              (dec_instr3),
    .dec_wr_en               (dec_wr_en),
    .dec_wr_reg              (dec_wr_reg),
    .reg_busy                (reg_busy),
    .rf_rd_addr              (rf_rd_addr),
    .rf_rd_data              (rf_rd_data),
    .wb_en                   (wb_en),
    .wb_reg                  (wb_reg),
    .wb_data                 (wb_data),
    .jump_base_from_rf_0     (jump_base_from_rf_0),
    .jump_base_rdy_from_rf_0 (jump_base_rdy_from_rf_0),
    .jr_busy                 (jr_busy),
    .jr_stall_cycles         (jr_stall_cycles)
  );

  assign rf_rd_data = rf_mem[rf_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bundle();
    dec_instr0 = '0;
    dec_instr1 = '0;
    dec_instr2 = '0;
    dec_instr3 = '0;
    dec_wr_en  = '0;
    dec_wr_reg = '0;
  endtask

  task automatic clear_wb();
    wb_en   = '0;
    wb_reg  = '0;
    wb_data = '0;
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_base"},  32'(jump_base_from_rf_0),     32'h0);
    check({tag, "_rdy"},   32'(jump_base_rdy_from_rf_0), 32'h0);
    check({tag, "_busy"},  32'(jr_busy),                 32'h0);
    check({tag, "_stall"}, 32'(jr_stall_cycles),         32'h0);
    check({tag, "_addr"},  32'(rf_rd_addr),              32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 16'h1000 + 16'(i);
    rf_mem[0] = 16'hDEAD;
    rf_mem[1] = 16'h1111;
    rf_mem[2] = 16'h2222;
    rf_mem[3] = 16'h1234;
    rf_mem[4] = 16'h4444;
    rf_mem[5] = 16'h5555;
    rf_mem[7] = 16'h0777;

    rst            = 1'b1;
    has_mispredict = 1'b0;
    reg_busy       = '0;
    clear_bundle();
    clear_wb();
    step();
    step();
    check_all_reset("reset");
    rst = 1'b0;
    step();

    // 1: slot2 jump on r3, nothing busy -> pulse at T+2 with r3.
    dec_instr2 = 16'hF301;
    step();
    clear_bundle();
    check("t1_busy", 32'(jr_busy), 32'h1);
    check("t1_addr", 32'(rf_rd_addr), 32'h3);
    check("t1_rdy_early", 32'(jump_base_rdy_from_rf_0), 32'h0);
    step();
    check("t1_rdy", 32'(jump_base_rdy_from_rf_0), 32'h1);
    check("t1_data", 32'(jump_base_from_rf_0), 32'h1234);
    step();
    check("t1_rdy_drop", 32'(jump_base_rdy_from_rf_0), 32'h0);
    check("t1_idle", 32'(jr_busy), 32'h0);

    // 2: slot1 jump on r5 with older slot0 writer of r5; wb port1 at T+4.
    dec_instr0 = 16'h1000;
    dec_instr1 = 16'hF501;
    dec_wr_en  = 4'b0001;
    dec_wr_reg = 16'h0005;
    step();                               // T+1
    clear_bundle();
    check("t2_wait1", 32'(jump_base_rdy_from_rf_0), 32'h0);
    step();                               // T+2
    check("t2_wait2", 32'(jump_base_rdy_from_rf_0), 32'h0);
    step();                               // T+3
    check("t2_wait3", 32'(jump_base_rdy_from_rf_0), 32'h0);
    check("t2_busy", 32'(jr_busy), 32'h1);
    step();                               // T+4
    wb_en   = 2'b11;
    wb_reg  = {4'd5, 4'd9};
    wb_data = {16'hBEEF, 16'h9999};
    step();                               // T+5
    clear_wb();
    check("t2_rdy", 32'(jump_base_rdy_from_rf_0), 32'h1);
    check("t2_data", 32'(jump_base_from_rf_0), 32'hBEEF);
    check("t2_stall", 32'(jr_stall_cycles), 32'd3);
    step();
    check("t2_idle", 32'(jr_busy), 32'h0);

    // 3: base r0 while reg_busy[0] is set -> zero, no wait.
    dec_instr0 = 16'hF001;
    reg_busy   = 16'h0001;
    step();
    clear_bundle();
    step();
    check("t3_rdy", 32'(jump_base_rdy_from_rf_0), 32'h1);
    check("t3_data", 32'(jump_base_from_rf_0), 32'h0000);
    step();
    reg_busy = '0;

    // 4: capture-cycle writeback to busy r7 -> bypass value.
    dec_instr0 = 16'hF701;
    reg_busy   = 16'h0080;
    wb_en      = 2'b01;
    wb_reg     = {4'd0, 4'd7};
    wb_data    = {16'h0000, 16'h00AA};
    step();
    clear_bundle();
    clear_wb();
    step();
    check("t4_rdy", 32'(jump_base_rdy_from_rf_0), 32'h1);
    check("t4_data", 32'(jump_base_from_rf_0), 32'h00AA);
    check("t4_stall", 32'(jr_stall_cycles), 32'd3);
    step();
    reg_busy = '0;

    // 5: mispredict while waiting on busy r6; jump and wb in that cycle ignored.
    dec_instr0 = 16'hF601;
    reg_busy   = 16'h0040;
    step();                               // T+1 WAIT
    clear_bundle();
    step();                               // T+2 WAIT
    check("t5_stall_pre", 32'(jr_stall_cycles), 32'd4);
    has_mispredict = 1'b1;
    dec_instr0     = 16'hF101;
    wb_en          = 2'b01;
    wb_reg         = {4'd0, 4'd6};
    wb_data        = {16'h0000, 16'h6666};
    step();
    has_mispredict = 1'b0;
    clear_bundle();
    clear_wb();
    check("t5_flush_idle", 32'(jr_busy), 32'h0);
    check("t5_flush_rdy", 32'(jump_base_rdy_from_rf_0), 32'h0);
    check("t5_stall_held", 32'(jr_stall_cycles), 32'd4);
    check("t5_base_held", 32'(jump_base_from_rf_0), 32'h00AA);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_rdy", 32'(jump_base_rdy_from_rf_0), 32'h0);
      check("t5_stay_idle", 32'(jr_busy), 32'h0);
    end
    reg_busy   = '0;
    dec_instr0 = 16'hF401;
    step();
    clear_bundle();
    step();
    check("t5_new_rdy", 32'(jump_base_rdy_from_rf_0), 32'h1);
    check("t5_new_data", 32'(jump_base_from_rf_0), 32'h4444);
    step();

    // 6: non-register jump in slot0, register jumps in slot1 (r1) and slot3 (r2).
    dec_instr0 = 16'hF300;
    dec_instr1 = 16'hF101;
    dec_instr3 = 16'hF201;
    step();
    clear_bundle();
    check("t6_addr", 32'(rf_rd_addr), 32'h1);
    step();
    check("t6_rdy", 32'(jump_base_rdy_from_rf_0), 32'h1);
    check("t6_data", 32'(jump_base_from_rf_0), 32'h1111);
    step();
    check("t6_idle", 32'(jr_busy), 32'h0);

    // 7: reset in the middle of a wait.
    dec_instr0 = 16'hF601;
    reg_busy   = 16'h0040;
    step();
    clear_bundle();
    step();
    check("t7_stall_pre", 32'(jr_stall_cycles), 32'd5);
    rst = 1'b1;
    step();
    check_all_reset("t7_rst");
    rst      = 1'b0;
    reg_busy = '0;
    step();
    check("t7_after", 32'(jr_busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
